psum_drain_acc: RTL and testbench



---
 rtl/psum_pkg.sv | 8 +
 rtl/psum_drain_acc_if.sv | 16 +
 rtl/sat_add.sv | 14 +
 rtl/psum_drain_acc.sv | 79 +++++++
 tb/tb_psum_drain_acc.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_pkg.sv
// psum_pkg: shared widths, saturation limits and FSM states for the psum drain accumulator
package psum_pkg;
  localparam int SUM_BW_D = 22;
  localparam int ACC_BW_D = 24;
  localparam longint ACC_MAX_D = (longint'(1) << (ACC_BW_D - 1)) - 1;
  localparam longint ACC_MIN_D = -(longint'(1) << (ACC_BW_D - 1));
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
endpackage

// File: rtl/psum_drain_acc_if.sv
// psum_drain_acc_if: FIFO read port plus valid/ready result port of the psum drain accumulator
interface psum_drain_acc_if
  import psum_pkg::*;
#(
  parameter int SUM_BW = SUM_BW_D,
  parameter int ACC_BW = ACC_BW_D
);
  logic              fifo_empty;
  logic              fifo_rd;
  logic [SUM_BW-1:0] fifo_data;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_BW-1:0] res_data;
  modport master(input fifo_empty, fifo_data, res_ready, output fifo_rd, res_valid, res_data);
  modport slave(output fifo_empty, fifo_data, res_ready, input fifo_rd, res_valid, res_data);
endinterface

// File: rtl/sat_add.sv
// sat_add: combinational signed saturating adder with overflow flag
module sat_add #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                ovf_o
);
  logic signed [W:0] full;
  assign full  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  assign ovf_o = full[W] ^ full[W-1];
  assign sum_o = ovf_o ? {full[W], {(W-1){~full[W]}}} : full[W-1:0];
endmodule

// File: rtl/psum_drain_acc.sv
// psum_drain_acc: pops partial sums from the psum FIFO read side and emits
// saturated, optionally ReLU'd sums of ACC_LEN words on a valid/ready port
module psum_drain_acc
  import psum_pkg::*;
#(
  parameter int SUM_BW  = SUM_BW_D,
  parameter int ACC_BW  = ACC_BW_D,
  parameter int ACC_LEN = 9,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic relu_en,
  output logic sat,
  output logic busy,
  psum_drain_acc_if.master bus
);
  state_t state_q, state_d;
  logic signed [ACC_BW-1:0] acc_q, acc_d, res_q, res_d, ext, sum;
  logic [CNT_W-1:0] issued_q, issued_d, recv_q, recv_d;
  logic rd_q, arm_q, sat_q, sat_d, ovf, last, start;
  assign ext = ACC_BW'($signed(bus.fifo_data));
  sat_add #(.W(ACC_BW)) u_add (.a_i(acc_q), .b_i(ext), .sum_o(sum), .ovf_o(ovf));
  // arm_q keeps the first FETCH cycle read-free so each group has one setup bubble
  assign bus.fifo_rd   = state_q == FETCH && arm_q && issued_q < CNT_W'(ACC_LEN) && !bus.fifo_empty;
  assign last          = rd_q && recv_q == CNT_W'(ACC_LEN - 1);
  assign start         = run && (state_q == IDLE || (state_q == DONE && bus.res_ready));
  assign bus.res_valid = state_q == DONE;
  assign bus.res_data  = res_q;
  assign sat           = sat_q;
  assign busy          = state_q != IDLE;
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    sat_d    = sat_q;
    res_d    = res_q;
    if (start) begin
      state_d  = FETCH;
      acc_d    = '0;
      issued_d = '0;
      recv_d   = '0;
      sat_d    = 1'b0;
    end else if (state_q == DONE && bus.res_ready) begin
      state_d = IDLE;
    end
    if (state_q == FETCH) begin
      issued_d = issued_q + CNT_W'(bus.fifo_rd);
      acc_d    = rd_q ? sum : acc_q;
      sat_d    = sat_q | (rd_q & ovf);
      recv_d   = recv_q + CNT_W'(rd_q);
      state_d  = last ? DONE : FETCH;
      res_d    = last ? ((relu_en && sum[ACC_BW-1]) ? '0 : sum) : res_q;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      res_q    <= '0;
      issued_q <= '0;
      recv_q   <= '0;
      rd_q     <= 1'b0;
      arm_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      rd_q     <= bus.fifo_rd;
      arm_q    <= state_q == FETCH;
      sat_q    <= sat_d;
    end
  end
endmodule

// File: tb/tb_psum_drain_acc.sv
// tb_psum_drain_acc: randomized bench with a FIFO model and a group-sum reference model
module tb_psum_drain_acc;
  import psum_pkg::*;
  localparam int SUM_BW = 22;
  localparam int ACC_BW = 24;
  localparam int ACC_LEN = 9;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic run = 1'b0;
  logic relu_en = 1'b0;
  logic sat, busy, hold;
  int checks = 0, failures = 0;
  int cyc = 0, pops = 0, viol = 0, run_len = 0, max_run = 0, last_rd = 0, vstart = 0, vcnt = 0;
  logic prev_valid = 1'b0;
  longint q[$];
  longint grp[$];
  logic [ACC_BW:0] exp_q[$];
  logic [ACC_BW:0] got_q[$];

  psum_drain_acc_if #(.SUM_BW(SUM_BW), .ACC_BW(ACC_BW)) bus ();
  psum_drain_acc #(.SUM_BW(SUM_BW), .ACC_BW(ACC_BW), .ACC_LEN(ACC_LEN), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .run(run), .relu_en(relu_en), .sat(sat), .busy(busy), .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [ACC_BW:0] model(input longint ws[$], input logic relu);
    longint a = 0;
    logic s = 1'b0;
    foreach (ws[i]) begin
      a = a + ws[i];
      if (a > ACC_MAX_D) begin a = ACC_MAX_D; s = 1'b1; end
      if (a < ACC_MIN_D) begin a = ACC_MIN_D; s = 1'b1; end
    end
    if (relu && a < 0) a = 0;
    return {s, a[ACC_BW-1:0]};
  endfunction

  function automatic longint rnd_word();
    return longint'($urandom_range(0, (1 << SUM_BW) - 1)) - (longint'(1) << (SUM_BW - 1));
  endfunction

  task automatic push(input longint w);
    q.push_back(w);
    bus.fifo_empty = hold;
  endtask

  // one clock: sample at negedge, then service the FIFO just after posedge
  task automatic tick();
    logic pop;
    longint w;
    @(negedge clk);
    pop = bus.fifo_rd;
    if (bus.fifo_rd && bus.fifo_empty) viol++;
    run_len = bus.fifo_rd ? run_len + 1 : 0;
    if (run_len > max_run) max_run = run_len;
    if (bus.fifo_rd) last_rd = cyc;
    if (bus.res_valid && !prev_valid) vstart = cyc;
    if (bus.res_valid) vcnt++;
    prev_valid = bus.res_valid;
    if (bus.res_valid && bus.res_ready) got_q.push_back({sat, bus.res_data});
    cyc++;
    @(posedge clk);
    #1;
    if (!rstn) grp.delete();
    if (pop && q.size() > 0) begin
      w = q.pop_front();
      pops++;
      bus.fifo_data = w[SUM_BW-1:0];
      grp.push_back(w);
      if (grp.size() == ACC_LEN) begin
        exp_q.push_back(model(grp, relu_en));
        grp.delete();
      end
    end
    bus.fifo_empty = hold || q.size() == 0;
  endtask

  task automatic clear_stats();
    got_q.delete();
    exp_q.delete();
    viol = 0; run_len = 0; max_run = 0; vcnt = 0;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    repeat (3) tick();
    checks += 5;
    if (bus.fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_fifo_rd got=%b exp=0", bus.fifo_rd); end
    if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    if (bus.res_data !== '0) begin failures++; $display("FAIL reset_res_data got=%h exp=0", bus.res_data); end
    if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", sat); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_sequence();
    clear_stats();
    for (int i = 1; i <= 9; i++) push(i);
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 100 && got_q.size() < 1; i++) tick();
    repeat (3) tick();
    checks += 5;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      failures++; $display("FAIL seq_count got=%0d exp=1 model=%0d", got_q.size(), exp_q.size());
    end else if (got_q[0] !== exp_q[0] || got_q[0] !== {1'b0, 24'd45}) begin
      failures++; $display("FAIL seq_sum got=%h exp=%h", got_q[0], exp_q[0]);
    end
    if (max_run != 9) begin failures++; $display("FAIL seq_rd_burst got=%0d exp=9", max_run); end
    if (vstart - last_rd != 2) begin failures++; $display("FAIL seq_latency got=%0d exp=2", vstart - last_rd); end
    if (vcnt != 1) begin failures++; $display("FAIL seq_valid_cycles got=%0d exp=1", vcnt); end
    if (busy !== 1'b0) begin failures++; $display("FAIL seq_idle got=%b exp=0", busy); end
  endtask

  task automatic test_negative(input logic relu);
    clear_stats();
    relu_en = relu;
    repeat (9) push(-5);
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 100 && got_q.size() < 1; i++) tick();
    repeat (2) tick();
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      failures++; $display("FAIL neg_count relu=%b got=%0d exp=1", relu, got_q.size());
    end else if (got_q[0] !== exp_q[0] || got_q[0][ACC_BW-1:0] !== (relu ? 24'h0 : 24'hFFFFD3)) begin
      failures++; $display("FAIL neg_sum relu=%b got=%h exp=%h", relu, got_q[0], exp_q[0]);
    end
    relu_en = 1'b0;
  endtask

  task automatic test_stall();
    clear_stats();
    repeat (4) push(2);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (30) tick();
    checks += 2;
    if (got_q.size() != 0) begin failures++; $display("FAIL stall_early got=%0d exp=0", got_q.size()); end
    if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", busy); end
    repeat (5) push(2);
    for (int i = 0; i < 100 && got_q.size() < 1; i++) tick();
    repeat (2) tick();
    checks += 2;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0] !== {1'b0, 24'd18}) begin
      failures++; $display("FAIL stall_sum got=%h exp=%h", got_q.size() ? got_q[0] : '0, {1'b0, 24'd18});
    end
    if (viol != 0) begin failures++; $display("FAIL stall_rd_when_empty got=%0d exp=0", viol); end
  endtask

  task automatic test_saturation();
    clear_stats();
    repeat (9) push((longint'(1) << 21) - 1);
    repeat (9) push(1);
    run = 1'b1;
    for (int i = 0; i < 100 && got_q.size() < 1; i++) tick();
    run = 1'b0;
    for (int i = 0; i < 100 && got_q.size() < 2; i++) tick();
    repeat (2) tick();
    checks += 2;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      failures++; $display("FAIL sat_count got=%0d exp=2", got_q.size());
    end else begin
      if (got_q[0] !== exp_q[0] || got_q[0] !== {1'b1, 24'h7FFFFF}) begin
        failures++; $display("FAIL sat_clamp got=%h exp=%h", got_q[0], exp_q[0]);
      end
      if (got_q[1] !== exp_q[1] || got_q[1] !== {1'b0, 24'd9}) begin
        failures++; $display("FAIL sat_clear got=%h exp=%h", got_q[1], exp_q[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [ACC_BW-1:0] d0;
    int bad = 0;
    clear_stats();
    bus.res_ready = 1'b0;
    repeat (18) push(rnd_word());
    run = 1'b1;
    for (int i = 0; i < 100 && !bus.res_valid; i++) tick();
    d0 = bus.res_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_data !== d0 || bus.fifo_rd !== 1'b0) bad++;
    end
    checks += 4;
    if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", bad); end
    bus.res_ready = 1'b1;
    tick();
    run = 1'b0;
    if (bus.res_valid !== 1'b0 || busy !== 1'b1 || bus.fifo_rd !== 1'b0) begin
      failures++; $display("FAIL bp_restart got=v%b b%b r%b exp=v0 b1 r0", bus.res_valid, busy, bus.fifo_rd);
    end
    tick();
    if (bus.fifo_rd !== 1'b1) begin failures++; $display("FAIL bp_first_rd got=%b exp=1", bus.fifo_rd); end
    for (int i = 0; i < 100 && got_q.size() < 2; i++) tick();
    repeat (2) tick();
    if (got_q.size() != 2 || exp_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      failures++; $display("FAIL bp_sums got=%0d results exp=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    clear_stats();
    relu_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < 6 * ACC_LEN; i++) push(rnd_word());
    run = 1'b1;
    for (int i = 0; i < 3000 && got_q.size() < 6; i++) begin
      tick();
      if (got_q.size() >= 5) run = 1'b0;
      hold = $urandom_range(0, 3) == 0;
      bus.res_ready = $urandom_range(0, 2) != 0;
      bus.fifo_empty = hold || q.size() == 0;
    end
    hold = 1'b0;
    bus.res_ready = 1'b1;
    bus.fifo_empty = q.size() == 0;
    repeat (3) tick();
    checks++;
    if (got_q.size() != 6 || exp_q.size() != 6) begin
      failures++; $display("FAIL rand_count got=%0d exp=6 model=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_grp%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL rand_rd_when_empty got=%0d exp=0", viol); end
    relu_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int p0;
    clear_stats();
    for (int i = 0; i < ACC_LEN; i++) push(rnd_word());
    p0 = pops;
    run = 1'b1;
    for (int i = 0; i < 100 && pops - p0 < 5; i++) tick();
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.fifo_rd !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== '0 || sat !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs got=r%b v%b d%h s%b b%b exp=all 0", bus.fifo_rd, bus.res_valid, bus.res_data, sat, busy);
    end
    repeat (2) tick();
    rstn = 1'b1;
    repeat (5) push(rnd_word());
    tick();
    run = 1'b0;
    for (int i = 0; i < 100 && got_q.size() < 1; i++) tick();
    repeat (2) tick();
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL midreset_sum got=%h exp=%h", got_q.size() ? got_q[0] : '0, exp_q.size() ? exp_q[0] : '0);
    end
  endtask

  initial begin
    hold = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_sequence();
    test_negative(1'b0);
    test_negative(1'b1);
    test_stall();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
